// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC stream controller.
// State encoding, mode values and counter-width helper.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ENCODE = 1'b0;
  localparam logic MODE_CHECK  = 1'b1;

  function automatic int cnt_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/crc_bit_counter.sv
// Shift-index counter with clear, enable and terminal-count flag.
// Wraps to zero on the terminal count so the index is 0 after a frame.
module crc_bit_counter
  import crc_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int LAST  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);

  assign tc = (count == LAST_C);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/crc_stream_controller.sv
// Sequencer for a bit-serial CRC datapath: load, shift, report.
// Accepts one frame at a time and holds the result until taken.
module crc_stream_controller
  import crc_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int CRC_W     = 4,
  localparam int SHIFT_LEN = DATA_W + CRC_W,
  localparam int CNT_W     = cnt_width(SHIFT_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic             abort,
  input  logic             syndrome_zero,
  output logic             load_en,
  output logic             shift_en,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             mode_q,
  output logic             crc_err,
  output logic             busy
);

  state_t state;
  state_t state_n;
  logic   cnt_en;
  logic   cnt_clr;
  logic   cnt_tc;
  logic   accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_ENCODE;
    end else if (accept) begin
      mode_q <= mode;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        load_en  = in_valid;
        if (in_valid) state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
        cnt_en   = 1'b1;
        if (abort)       state_n = ST_IDLE;
        else if (cnt_tc) state_n = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (abort || out_ready) state_n = ST_IDLE;
      end
      default: begin
        in_ready = 1'b1;
        load_en  = in_valid;
        state_n  = ST_IDLE;
      end
    endcase
    // Reset forces idle-looking outputs even before the first edge lands.
    if (rst) begin
      in_ready  = 1'b1;
      load_en   = in_valid;
      shift_en  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      cnt_en    = 1'b0;
    end
  end

  assign accept  = (state == ST_IDLE) && in_valid;
  assign cnt_clr = (state != ST_SHIFT) || abort;
  assign crc_err = out_valid && (mode_q == MODE_CHECK)
                && !syndrome_zero;

  crc_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (SHIFT_LEN - 1)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .count  (bit_cnt),
    .tc     (cnt_tc)
  );

endmodule

// File: tb/tb_crc_stream_controller.sv
// Self-checking bench for crc_stream_controller.
// Directed scenarios plus a randomized run against a frame-phase model.
module tb_crc_stream_controller;
  import crc_pkg::*;

  localparam int L  = 12;
  localparam int LW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, mode, abort, syndrome_zero, out_ready;
  logic       in_ready, load_en, shift_en, out_valid, mode_q;
  logic       crc_err, busy;
  logic [3:0] bit_cnt;

  logic       w_rst, w_in_valid, w_mode, w_abort, w_sz, w_out_ready;
  logic       w_in_ready, w_load_en, w_shift_en, w_out_valid, w_mode_q;
  logic       w_crc_err, w_busy;
  logic [4:0] w_bit_cnt;

  int pass_cnt = 0;
  int total    = 0;

  crc_stream_controller #(.DATA_W(8), .CRC_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .abort(abort), .syndrome_zero(syndrome_zero),
    .load_en(load_en), .shift_en(shift_en), .bit_cnt(bit_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .mode_q(mode_q),
    .crc_err(crc_err), .busy(busy)
  );

  crc_stream_controller #(.DATA_W(16), .CRC_W(16)) dut_w (
    .clk(clk), .rst(w_rst), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .mode(w_mode), .abort(w_abort),
    .syndrome_zero(w_sz), .load_en(w_load_en),
    .shift_en(w_shift_en), .bit_cnt(w_bit_cnt),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .mode_q(w_mode_q), .crc_err(w_crc_err), .busy(w_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; mode = 0; abort = 0;
    syndrome_zero = 0; out_ready = 0;
    w_rst = 1; w_in_valid = 0; w_mode = 0; w_abort = 0;
    w_sz = 0; w_out_ready = 0;
    step(); step(); mid();
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total++; if (shift_en !== 1'b0) $display("FAIL rst_shift_en got=%b exp=0", shift_en); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (crc_err !== 1'b0) $display("FAIL rst_crc_err got=%b exp=0", crc_err); else pass_cnt++;
    total++; if (bit_cnt !== 4'd0) $display("FAIL rst_bit_cnt got=%0d exp=0", bit_cnt); else pass_cnt++;
    total++; if (mode_q !== 1'b0) $display("FAIL rst_mode_q got=%b exp=0", mode_q); else pass_cnt++;
    total++; if (w_busy !== 1'b0) $display("FAIL rst_w_busy got=%b exp=0", w_busy); else pass_cnt++;
    in_valid = 1;
    #1;
    total++; if (load_en !== 1'b1) $display("FAIL rst_load_en got=%b exp=1", load_en); else pass_cnt++;
    in_valid = 0;
    #1;
    total++; if (load_en !== 1'b0) $display("FAIL rst_load_en_lo got=%b exp=0", load_en); else pass_cnt++;
    step();
    rst = 0; w_rst = 0;
  endtask

  task automatic test_encode();
    int shifts = 0;
    int vcyc = -1;
    int bad = 0;
    mode = MODE_ENCODE; out_ready = 1; syndrome_zero = 0; in_valid = 1;
    mid();
    total++; if (load_en !== 1'b1) $display("FAIL enc_load_en got=%b exp=1", load_en); else pass_cnt++;
    step();
    in_valid = 0;
    for (int c = 1; c <= 40 && vcyc < 0; c++) begin
      mid();
      if (shift_en === 1'b1) begin
        if (bit_cnt !== 4'(shifts)) bad++;
        shifts++;
      end
      if (out_valid === 1'b1) begin
        vcyc = c;
        total++; if (crc_err !== 1'b0) $display("FAIL enc_crc_err got=%b exp=0", crc_err); else pass_cnt++;
        total++; if (bit_cnt !== 4'd0) $display("FAIL enc_done_cnt got=%0d exp=0", bit_cnt); else pass_cnt++;
      end
      step();
    end
    total++; if (vcyc != L + 1) $display("FAIL enc_latency got=%0d exp=%0d", vcyc, L + 1); else pass_cnt++;
    total++; if (shifts != L) $display("FAIL enc_shifts got=%0d exp=%0d", shifts, L); else pass_cnt++;
    total++; if (bad != 0) $display("FAIL enc_bit_seq got=%0d exp=0 bad", bad); else pass_cnt++;
    mid();
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL enc_idle got=%b%b exp=01", busy, in_ready); else pass_cnt++;
    step();
  endtask

  task automatic test_check();
    bit found = 0;
    mode = MODE_CHECK; in_valid = 1; out_ready = 0;
    step();
    in_valid = 0; mode = MODE_ENCODE;
    for (int c = 0; c < 40; c++) begin
      mid();
      if (out_valid === 1'b1) begin found = 1; break; end
      step();
    end
    total++; if (!found) $display("FAIL chk_wait got=timeout exp=out_valid"); else pass_cnt++;
    syndrome_zero = 0;
    #1;
    total++; if (crc_err !== 1'b1) $display("FAIL chk_err got=%b exp=1", crc_err); else pass_cnt++;
    total++; if (mode_q !== 1'b1) $display("FAIL chk_mode_q got=%b exp=1", mode_q); else pass_cnt++;
    syndrome_zero = 1;
    #1;
    total++; if (crc_err !== 1'b0) $display("FAIL chk_ok got=%b exp=0", crc_err); else pass_cnt++;
    syndrome_zero = 0; out_ready = 1;
    step(); mid();
    total++; if (out_valid !== 1'b0 || crc_err !== 1'b0) $display("FAIL chk_after got=%b%b exp=00", out_valid, crc_err); else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    bit found = 0;
    int vc = 0;
    mode = MODE_ENCODE; in_valid = 1; out_ready = 0;
    step();
    in_valid = 0;
    for (int c = 0; c < 40; c++) begin
      mid();
      if (out_valid === 1'b1) begin found = 1; break; end
      step();
    end
    total++; if (!found) $display("FAIL bp_wait got=timeout exp=out_valid"); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) mid();
      if (out_valid === 1'b1 && shift_en === 1'b0) vc++;
      if (i == 5) out_ready = 1;
      step();
    end
    total++; if (vc != 6) $display("FAIL bp_hold got=%0d exp=6", vc); else pass_cnt++;
    mid();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_idle got=%b%b exp=01", out_valid, in_ready); else pass_cnt++;
    step();
  endtask

  task automatic test_abort();
    bit found = 0;
    int shifts = 0;
    bit seen = 0;
    mode = MODE_ENCODE; in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    for (int c = 0; c < 40; c++) begin
      mid();
      if (shift_en === 1'b1 && bit_cnt === 4'd5) begin found = 1; break; end
      step();
    end
    total++; if (!found) $display("FAIL ab_wait got=timeout exp=bit_cnt5"); else pass_cnt++;
    abort = 1;
    #1;
    total++; if (shift_en !== 1'b1 || bit_cnt !== 4'd5) $display("FAIL ab_same_cycle got=%b/%0d exp=1/5", shift_en, bit_cnt); else pass_cnt++;
    step();
    abort = 0;
    mid();
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL ab_idle got=%b%b%b exp=100", in_ready, busy, out_valid); else pass_cnt++;
    total++; if (bit_cnt !== 4'd0) $display("FAIL ab_cnt got=%0d exp=0", bit_cnt); else pass_cnt++;
    in_valid = 1;
    step();
    in_valid = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      mid();
      if (shift_en === 1'b1) shifts++;
      if (out_valid === 1'b1) seen = 1;
      step();
    end
    total++; if (shifts != L || !seen) $display("FAIL ab_refill got=%0d exp=%0d", shifts, L); else pass_cnt++;
  endtask

  task automatic test_abort_idle_done();
    bit found = 0;
    abort = 1; in_valid = 1; out_ready = 0;
    mid();
    total++; if (in_ready !== 1'b1) $display("FAIL abi_ready got=%b exp=1", in_ready); else pass_cnt++;
    step();
    abort = 0; in_valid = 0;
    mid();
    total++; if (shift_en !== 1'b1 || bit_cnt !== 4'd0) $display("FAIL abi_accept got=%b/%0d exp=1/0", shift_en, bit_cnt); else pass_cnt++;
    step();
    for (int c = 0; c < 40; c++) begin
      mid();
      if (out_valid === 1'b1) begin found = 1; break; end
      step();
    end
    total++; if (!found) $display("FAIL abd_wait got=timeout exp=out_valid"); else pass_cnt++;
    abort = 1;
    step();
    abort = 0;
    mid();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL abd_drop got=%b%b exp=01", out_valid, in_ready); else pass_cnt++;
    step();
  endtask

  task automatic test_rst_mid();
    bit found = 0;
    in_valid = 1; mode = MODE_CHECK; out_ready = 1;
    step();
    in_valid = 0;
    for (int c = 0; c < 40; c++) begin
      mid();
      if (shift_en === 1'b1 && bit_cnt === 4'd7) begin found = 1; break; end
      step();
    end
    total++; if (!found) $display("FAIL rm_wait got=timeout exp=bit_cnt7"); else pass_cnt++;
    rst = 1;
    step();
    rst = 0;
    mid();
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || bit_cnt !== 4'd0) $display("FAIL rm_idle got=%b%b/%0d exp=10/0", in_ready, busy, bit_cnt); else pass_cnt++;
    total++; if (mode_q !== 1'b0) $display("FAIL rm_mode_q got=%b exp=0", mode_q); else pass_cnt++;
    step();
  endtask

  task automatic test_wide();
    bit found = 0;
    int shifts = 0;
    int peak = 0;
    int vcyc = -1;
    w_in_valid = 1; w_mode = 1; w_out_ready = 1; w_sz = 0;
    step();
    w_in_valid = 0;
    for (int c = 0; c < 60; c++) begin
      mid();
      if (w_shift_en === 1'b1 && w_bit_cnt === 5'd7) begin found = 1; break; end
      step();
    end
    total++; if (!found) $display("FAIL wd_wait got=timeout exp=bit_cnt7"); else pass_cnt++;
    w_rst = 1;
    step();
    w_rst = 0;
    mid();
    total++; if (w_busy !== 1'b0 || w_bit_cnt !== 5'd0) $display("FAIL wd_rst got=%b/%0d exp=0/0", w_busy, w_bit_cnt); else pass_cnt++;
    w_in_valid = 1;
    #1;
    total++; if (w_load_en !== 1'b1 || w_in_ready !== 1'b1) $display("FAIL wd_load got=%b%b exp=11", w_load_en, w_in_ready); else pass_cnt++;
    step();
    w_in_valid = 0;
    for (int c = 1; c <= 80 && vcyc < 0; c++) begin
      mid();
      if (w_shift_en === 1'b1) begin
        shifts++;
        if (int'(w_bit_cnt) > peak) peak = int'(w_bit_cnt);
      end
      if (w_out_valid === 1'b1) begin
        vcyc = c;
        total++; if (w_crc_err !== 1'b1 || w_mode_q !== 1'b1) $display("FAIL wd_err got=%b%b exp=11", w_crc_err, w_mode_q); else pass_cnt++;
      end
      step();
    end
    total++; if (shifts != LW) $display("FAIL wd_shifts got=%0d exp=%0d", shifts, LW); else pass_cnt++;
    total++; if (peak != LW - 1) $display("FAIL wd_peak got=%0d exp=%0d", peak, LW - 1); else pass_cnt++;
    total++; if (vcyc != LW + 1) $display("FAIL wd_latency got=%0d exp=%0d", vcyc, LW + 1); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int bad = 0;
    in_valid = 1; mode = MODE_ENCODE; out_ready = 1;
    for (int c = 0; c < 60; c++) begin
      mid();
      if (in_ready === 1'b1) acc.push_back(c);
      step();
    end
    in_valid = 0;
    for (int i = 1; i < acc.size(); i++)
      if (acc[i] - acc[i-1] != L + 2) bad++;
    total++; if (acc.size() < 4) $display("FAIL b2b_count got=%0d exp>=4", acc.size()); else pass_cnt++;
    total++; if (bad != 0) $display("FAIL b2b_period got=%0d exp=0 bad", bad); else pass_cnt++;
    abort = 1;
    step();
    abort = 0;
  endtask

  task automatic test_random();
    int k = 0;
    logic mq = 1'b0;
    logic [10:0] got, exp;
    rst = 1;
    step();
    rst = 0;
    for (int n = 0; n < 800; n++) begin
      in_valid      = ($urandom_range(1) == 0);
      mode          = ($urandom_range(1) == 0);
      abort         = ($urandom_range(39) == 0);
      syndrome_zero = ($urandom_range(1) == 0);
      out_ready     = ($urandom_range(2) == 0);
      mid();
      exp[10] = (k == 0);
      exp[9]  = (k == 0) && in_valid;
      exp[8]  = (k >= 1 && k <= L);
      exp[7]  = (k == L + 1);
      exp[6]  = (k != 0);
      exp[5]  = (k == L + 1) && mq && !syndrome_zero;
      exp[4]  = mq;
      exp[3:0] = (k >= 1 && k <= L) ? 4'(k - 1) : 4'd0;
      got = {in_ready, load_en, shift_en, out_valid, busy,
             crc_err, mode_q, bit_cnt};
      total++;
      if (got !== exp)
        $display("FAIL rnd_cycle%0d got=%b exp=%b", n, got, exp);
      else
        pass_cnt++;
      step();
      if (k == 0) begin
        if (in_valid) begin k = 1; mq = mode; end
      end else if (abort) begin
        k = 0;
      end else if (k <= L) begin
        k++;
      end else if (out_ready) begin
        k = 0;
      end
    end
    in_valid = 0; abort = 1;
    step();
    abort = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encode();
    test_check();
    test_backpressure();
    test_abort();
    test_abort_idle_done();
    test_rst_mid();
    test_wide();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/crc_stream_controller.md
CRC_STREAM_CONTROLLER -- requirements
Module: crc_stream_controller

Interface
REQ-001 Parameter DATA_W, default 8, message bits per frame, >=1.
REQ-002 Parameter CRC_W, default 4, CRC remainder bits, >=1.
REQ-003 Derived constant SHIFT_LEN = DATA_W+CRC_W; CNT_W = max(1, ceil(log2(SHIFT_LEN))).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_valid  in  1  frame request from upstream.
REQ-007 in_ready  out  1  controller can accept a frame.
REQ-008 mode  in  1  0=encode, 1=check; sampled on accept.
REQ-009 abort  in  1  cancel the current frame.
REQ-010 syndrome_zero  in  1  datapath remainder equals zero.
REQ-011 load_en  out  1  datapath loads message word.
REQ-012 shift_en  out  1  datapath shifts one bit.
REQ-013 bit_cnt  out  CNT_W  current shift index.
REQ-014 out_valid  out  1  result ready for downstream.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 mode_q  out  1  captured mode of the active frame.
REQ-017 crc_err  out  1  check-mode failure flag.
REQ-018 busy  out  1  frame in progress.

Function
REQ-019 FSM states: IDLE, SHIFT, DONE; Moore outputs only, except load_en.
REQ-020 IDLE: in_ready=1; load_en = in_valid; accept = in_valid & in_ready -> SHIFT, mode_q <= mode, bit_cnt <= 0.
REQ-021 SHIFT: shift_en=1, busy=1, in_ready=0; bit_cnt += 1 each cycle; at bit_cnt==SHIFT_LEN-1 -> DONE.
REQ-022 Exactly SHIFT_LEN shift_en cycles per non-aborted frame.
REQ-023 DONE: out_valid=1, busy=1, shift_en=0; held until out_valid & out_ready, then -> IDLE.
REQ-024 crc_err = out_valid & mode_q & ~syndrome_zero; 0 in encode mode and outside DONE.
REQ-025 Latency: accept at cycle 0 -> out_valid at cycle SHIFT_LEN+1; back-to-back period SHIFT_LEN+2 cycles with out_ready=1.
REQ-026 in_valid is ignored outside IDLE; no input queueing.
REQ-027 abort in SHIFT or DONE -> IDLE next cycle; current-cycle outputs unchanged.
REQ-028 abort in DONE with out_ready=1 counts as a completed transfer; without out_ready the result is discarded.
REQ-029 abort in IDLE is ignored, and in_valid in the same cycle is still accepted.
REQ-030 bit_cnt is 0 in IDLE and DONE; it never exceeds SHIFT_LEN-1.
REQ-031 An unreachable state encoding -> IDLE next cycle with all outputs at reset values.

Reset
REQ-032 rst=1 at a clock edge -> IDLE, bit_cnt=0, mode_q=0; this overrides every other input, including mid-SHIFT and mid-DONE.
REQ-033 While in reset: in_ready=1; shift_en=0, out_valid=0, busy=0, crc_err=0; load_en follows in_valid.

Structure
REQ-034 Shared package crc_pkg holds the state encoding and the MODE_ENCODE/MODE_CHECK constants.
REQ-035 One sub-module, crc_bit_counter (clear, enable, terminal-count flag), is instantiated for bit_cnt.

Verification
REQ-036 DATA_W=8, CRC_W=4, encode frame, out_ready=1 -> 12 shift_en cycles, out_valid at cycle 13, crc_err=0.
REQ-037 Check mode, syndrome_zero=0 in DONE -> crc_err=1 with out_valid; with syndrome_zero=1 -> crc_err=0.
REQ-038 out_ready held low 5 cycles in DONE -> out_valid stays 1 for 6 cycles, shift_en stays 0, then IDLE.
REQ-039 abort at bit_cnt=5 -> IDLE next cycle, no out_valid; a new frame accepted afterwards runs the full 12 shifts.
REQ-040 rst pulse at bit_cnt=7 -> IDLE next cycle, bit_cnt=0, busy=0; then repeat with DATA_W=16, CRC_W=16 -> 32 shifts, bit_cnt peaks at 31.
